booth_mul_r4_stream: RTL and testbench

- Iterative radix-4 Booth multiplier for the MSM field-arithmetic datapath. Generalises the one-shot Booth wrapper: it is re-triggerable and has a valid/ready handshake on both input and output.
- Adds a per-transaction signed/unsigned mode and any WIDTH (odd or even).
- Feeds Montgomery/Barrett reduction stages; one multiplication in flight.

---
 rtl/booth_mul_r4_stream.sv | 102 ++++++++++
 tb/tb_booth_mul_r4_stream.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_r4_stream.sv
// Iterative radix-4 Booth multiplier with valid/ready on both sides and per-op signed mode.
// Optional BOOTH_EARLY_TERM_EN: finish as soon as the remaining multiplier digits are all zero.
module booth_mul_r4_stream #(
  parameter int unsigned WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   ab,
  output logic                 busy
);

  localparam int unsigned ITER = (WIDTH + 2) / 2;
  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned MW   = WIDTH + 3;
  localparam int unsigned CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  // Product is taken mod 2^(2*WIDTH), so the two guard bits above PW never reach ab.
  logic [PW-1:0] acc;
  logic [PW-1:0] mcand;
  logic [MW-1:0] mplr;
  logic [CW-1:0] cnt;
  logic [PW-1:0] term_c;
  logic          finish_c;

  // Booth recode of the low three multiplier bits into the partial product.
  always_comb begin
    term_c = '0;
    case (mplr[2:0])
      3'b001, 3'b010: term_c = mcand;
      3'b011:         term_c = mcand << 1;
      3'b100:         term_c = -(mcand << 1);
      3'b101, 3'b110: term_c = -mcand;
      default:        term_c = '0;
    endcase
  end

`ifdef BOOTH_EARLY_TERM_EN
  always_comb finish_c = (cnt == CW'(ITER)) || (&mplr) || !(|mplr);
`else
  always_comb finish_c = (cnt == CW'(ITER));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      ab        <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplr      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            acc      <= '0;
            cnt      <= '0;
            mcand    <= {{WIDTH{signed_mode & a[WIDTH-1]}}, a};
            mplr     <= {{2{signed_mode & b[WIDTH-1]}}, b, 1'b0};
          end
        end
        CALC: begin
          if (finish_c) begin
            state     <= DONE;
            out_valid <= 1'b1;
            ab        <= acc;
          end else begin
            acc   <= acc + term_c;
            mcand <= mcand << 2;
            mplr  <= {{2{mplr[MW-1]}}, mplr[MW-1:2]};
            cnt   <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_r4_stream.sv
// Bench for booth_mul_r4_stream: four widths side by side, directed corners plus random regression.
module tb_booth_mul_r4_stream;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]   iv = '0;
  logic [3:0]   sm = '0;
  logic [3:0]   ordy = '0;
  wire  [3:0]   ir, ov, bz;
  logic [127:0] av [4];
  logic [127:0] bv [4];
  wire  [13:0]  ab0;
  wire  [15:0]  ab1;
  wire  [127:0] ab2;
  wire  [255:0] ab3;

  int n_asserts = 0;
  int n_fail = 0;

  booth_mul_r4_stream #(.WIDTH(7)) u_w7 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .signed_mode(sm[0]),
    .a(av[0][6:0]), .b(bv[0][6:0]), .out_valid(ov[0]), .out_ready(ordy[0]), .ab(ab0), .busy(bz[0]));
  booth_mul_r4_stream #(.WIDTH(8)) u_w8 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .signed_mode(sm[1]),
    .a(av[1][7:0]), .b(bv[1][7:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .ab(ab1), .busy(bz[1]));
  booth_mul_r4_stream #(.WIDTH(64)) u_w64 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .signed_mode(sm[2]),
    .a(av[2][63:0]), .b(bv[2][63:0]), .out_valid(ov[2]), .out_ready(ordy[2]), .ab(ab2), .busy(bz[2]));
  booth_mul_r4_stream #(.WIDTH(128)) u_w128 (
    .clk(clk), .reset(reset), .in_valid(iv[3]), .in_ready(ir[3]), .signed_mode(sm[3]),
    .a(av[3]), .b(bv[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .ab(ab3), .busy(bz[3]));

  function automatic int wid(input int k);
    case (k)
      0: return 7;
      1: return 8;
      2: return 64;
      default: return 128;
    endcase
  endfunction

  function automatic int iters(input int k);
    return (wid(k) + 2) / 2;
  endfunction

  function automatic logic [255:0] get_ab(input int k);
    case (k)
      0: return 256'(ab0);
      1: return 256'(ab1);
      2: return 256'(ab2);
      default: return ab3;
    endcase
  endfunction

  // Reference: extend each operand to 256 bits per mode, multiply, keep the low 2*WIDTH bits.
  function automatic logic [255:0] ref_mul(input int k, input logic s, input logic [127:0] x, input logic [127:0] y);
    int w;
    logic [255:0] lo, m, xe, ye;
    w  = wid(k);
    lo = (w == 128) ? {128'd0, {128{1'b1}}} : ((256'd1 << w) - 256'd1);
    m  = (w == 128) ? {256{1'b1}} : ((256'd1 << (2 * w)) - 256'd1);
    xe = 256'(x) & lo;
    ye = 256'(y) & lo;
    if (s && xe[w-1]) xe = xe | ~lo;
    if (s && ye[w-1]) ye = ye | ~lo;
    return (xe * ye) & m;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction; entered #1 after a rising edge with the DUT idle.
  task automatic mul(input int k, input logic s, input logic [127:0] x, input logic [127:0] y,
                     input logic [255:0] exp, input int exp_lat, input int gap_out, input string tag);
    int lat;
    logic [255:0] held;
    chk({tag, " in_ready before accept"}, 256'(ir[k]), 256'(1));
    iv[k] = 1'b1; sm[k] = s; av[k] = x; bv[k] = y;
    @(posedge clk); #1;
    iv[k] = 1'b0; sm[k] = ~s; av[k] = rnd128(); bv[k] = rnd128();
    chk({tag, " busy after accept"}, 256'({bz[k], ir[k]}), 256'(2'b10));
    lat = 0;
    while (!ov[k] && lat <= iters(k) + 3) begin
      iv[k] = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      lat++;
      if (!ov[k] && ir[k]) chk({tag, " in_ready while busy"}, 256'(ir[k]), 256'(0));
    end
    iv[k] = 1'b0;
    if (!ov[k]) begin
      chk({tag, " out_valid timeout"}, 256'(ov[k]), 256'(1));
      return;
    end
    if (exp_lat >= 0) chk({tag, " latency"}, 256'(lat), 256'(exp_lat));
`ifdef BOOTH_EARLY_TERM_EN
    else chk({tag, " latency in range"}, 256'(lat >= 1 && lat <= iters(k) + 1), 256'(1));
`else
    else chk({tag, " latency"}, 256'(lat), 256'(iters(k) + 1));
`endif
    chk({tag, " product"}, get_ab(k), exp);
    held = get_ab(k);
    repeat (gap_out) begin
      @(posedge clk); #1;
    end
    chk({tag, " held product"}, get_ab(k), held);
    chk({tag, " held handshake"}, 256'({ov[k], ir[k], bz[k]}), 256'(3'b101));
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
    chk({tag, " idle after handshake"}, 256'({ov[k], ir[k], bz[k]}), 256'(3'b010));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      av[k] = '0;
      bv[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++)
      chk($sformatf("reset state w%0d", wid(k)), {get_ab(k), 253'(0), ov[k], ir[k], bz[k]},
          {256'd0, 253'(0), 3'b010});
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed corners.
`ifdef BOOTH_EARLY_TERM_EN
    mul(1, 1'b0, 128'd3, 128'd5, 256'h000F, 3, 0, "w8 u 3*5");
    mul(3, 1'b0, {128{1'b1}}, {128{1'b1}}, {{127{1'b1}}, 1'b0, 127'd0, 1'b1}, -1, 1, "w128 u ones*ones");
`else
    mul(1, 1'b0, 128'd3, 128'd5, 256'h000F, 6, 0, "w8 u 3*5");
    mul(3, 1'b0, {128{1'b1}}, {128{1'b1}}, {{127{1'b1}}, 1'b0, 127'd0, 1'b1}, 66, 1, "w128 u ones*ones");
`endif
    mul(1, 1'b0, 128'hFF, 128'hFF, 256'hFE01, -1, 0, "w8 u ff*ff");
    mul(1, 1'b1, 128'hFF, 128'hFF, 256'h0001, -1, 2, "w8 s ff*ff");
    mul(1, 1'b1, 128'h80, 128'h7F, 256'hC080, -1, 0, "w8 s 80*7f");
    mul(1, 1'b1, 128'h80, 128'h80, 256'h4000, -1, 0, "w8 s 80*80");
    mul(0, 1'b1, 128'h40, 128'h40, 256'h1000, -1, 0, "w7 s 40*40");
    mul(0, 1'b1, 128'h40, 128'h3F, 256'h3040, -1, 0, "w7 s 40*3f");
    mul(2, 1'b1, 128'd0, rnd128(), 256'd0, -1, 0, "w64 s zero");

    // Backpressure: result waits 10 cycles, then a second pair goes in right after the handshake.
    iv[1] = 1'b1; sm[1] = 1'b0; av[1] = 128'd200; bv[1] = 128'd100;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    repeat (iters(1) + 1) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("backpressure cycle %0d", i), {get_ab(1), 253'(0), ov[1], ir[1], bz[1]},
          {256'h4E20, 253'(0), 3'b101});
      @(posedge clk); #1;
    end
    ordy[1] = 1'b1;
    @(posedge clk); #1;
    ordy[1] = 1'b0;
    chk("backpressure release", 256'({ov[1], ir[1]}), 256'(2'b01));
    mul(1, 1'b1, 128'hF6, 128'h0D, 256'hFF7E, -1, 0, "w8 s -10*13 after release");

    // Reset during CALC discards the operation.
    iv[1] = 1'b1; sm[1] = 1'b0; av[1] = 128'h55; bv[1] = 128'h33;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("reset mid calc", {get_ab(1), 253'(0), ov[1], ir[1], bz[1]}, {256'd0, 253'(0), 3'b010});
    @(posedge clk); #1;
    chk("no stale out_valid", 256'(ov[1]), 256'(0));
    mul(1, 1'b0, 128'd7, 128'd9, 256'd63, -1, 0, "w8 u 7*9 after reset");

    // Random regression across widths and modes.
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 150; n++) begin
        logic s;
        logic [127:0] x, y;
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
        s = 1'($urandom);
        x = rnd128();
        y = rnd128();
        if ($urandom_range(0, 9) == 0) x = (n % 2 == 0) ? '0 : {128{1'b1}};
        if ($urandom_range(0, 9) == 0) y = 128'(1) << (wid(k) - 1);
        mul(k, s, x, y, ref_mul(k, s, x, y), -1, $urandom_range(0, 3),
            $sformatf("rand w%0d #%0d", wid(k), n));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
